// File: rtl/shift_arb_pkg.sv
// Shared definitions for the shift_arbiter slice: FSM states and datapath widths.
package shift_arb_pkg;

    localparam int OP_W  = 8;
    localparam int AMT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/barrel_shifter.sv
// Three-stage logarithmic rotate-left of the operand; amount 0 passes it through.
module barrel_shifter
    import shift_arb_pkg::*;
(
    input  logic [OP_W-1:0]  data,
    input  logic [AMT_W-1:0] amt,
    output logic [OP_W-1:0]  result
);

    logic [OP_W-1:0] stage1;
    logic [OP_W-1:0] stage2;

    assign stage1 = amt[0] ? {data[OP_W-2:0], data[OP_W-1]} : data;
    assign stage2 = amt[1] ? {stage1[OP_W-3:0], stage1[OP_W-1:OP_W-2]} : stage1;
    assign result = amt[2] ? {stage2[OP_W-5:0], stage2[OP_W-1:OP_W-4]} : stage2;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after 'last' (modulo
// N_REQ) wins; the pointer register itself lives in the caller.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Walk last+1, last+2, ... so the most recent winner is checked last.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last) + k) % N_REQ);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of a single barrel_shifter among N_REQ valid/ready
// requesters; one operation in flight at a time, result tagged with its owner.
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*OP_W-1:0] req_data,
    input  logic [N_REQ*AMT_W-1:0] req_amt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [OP_W-1:0]       rsp_data,
    output logic [ID_W-1:0]       rsp_id
);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W-1:0]  last_q;
    logic [ID_W-1:0]  id_q;
    logic             arb_en;
    logic             grant;
    logic [OP_W-1:0]  sel_data;
    logic [AMT_W-1:0] sel_amt;
    logic [OP_W-1:0]  op_data_q;
    logic [AMT_W-1:0] op_amt_q;
    logic [OP_W-1:0]  shift_out;
    logic [OP_W-1:0]  rsp_data_q;

    // Gating with rst_n keeps req_ready low while reset is held.
    assign arb_en = (state_q == IDLE) && rst_n;
    assign grant  = |gnt;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req    (req_valid),
        .last   (last_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    barrel_shifter u_shift (
        .data   (op_data_q),
        .amt    (op_amt_q),
        .result (shift_out)
    );

    always_comb begin
        sel_data = '0;
        sel_amt  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_data = req_data[i*OP_W +: OP_W];
                sel_amt  = req_amt[i*AMT_W +: AMT_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = SHIFT;
            SHIFT:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pointer starts at N_REQ-1 so requester 0 has first priority after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= ID_W'(N_REQ - 1);
            id_q       <= '0;
            op_data_q  <= '0;
            op_amt_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                op_data_q <= sel_data;
                op_amt_q  <= sel_amt;
                id_q      <= gnt_id;
                last_q    <= gnt_id;
            end
            if (state_q == SHIFT) begin
                rsp_data_q <= shift_out;
            end
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = id_q;

endmodule
